// File: rtl/angle_output_sequencer.sv
`default_nettype none
// ============================================================================
// angle_output_sequencer : snapshots roll/pitch/yaw frames and walks the MCU
//                          through one strobe/done handshake per word.
// Revision 1.0
// ============================================================================
module angle_output_sequencer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             configured_in,
  input  logic             angles_valid_in,
  input  logic [15:0]      roll_in,
  input  logic [15:0]      pitch_in,
  input  logic [15:0]      yaw_in,
  input  logic             done_in,
  input  logic             clear_in,
  output logic [15:0]      roll_angle_out,
  output logic [15:0]      pitch_angle_out,
  output logic [15:0]      yaw_angle_out,
  output logic             write_enable_out,
  output logic [1:0]       output_select_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] frame_count_out,
  output logic [CNT_W-1:0] overrun_count_out,
  output logic             timeout_err_out
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [1:0] C_SEL_ROLL = 2'b00;
  localparam logic [1:0] C_SEL_YAW  = 2'b10;
  localparam logic [1:0] C_SEL_IDLE = 2'b11;

  logic [1:0]       r_state;
  logic [1:0]       r_sel;
  logic [TMR_W-1:0] r_timer;
  logic             w_overrun;

  assign w_overrun = angles_valid_in && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state           <= S_IDLE;
      r_sel             <= C_SEL_ROLL;
      r_timer           <= '0;
      roll_angle_out    <= '0;
      pitch_angle_out   <= '0;
      yaw_angle_out     <= '0;
      write_enable_out  <= 1'b0;
      output_select_out <= C_SEL_IDLE;
      busy_out          <= 1'b0;
      frame_count_out   <= '0;
      overrun_count_out <= '0;
      timeout_err_out   <= 1'b0;
    end else begin
      write_enable_out <= 1'b0;
      if (clear_in) timeout_err_out <= 1'b0;

      // A fresh overrun beats a coincident clear so the event is never lost.
      if (w_overrun) begin
        if (clear_in)
          overrun_count_out <= CNT_W'(1);
        else if (overrun_count_out != '1)
          overrun_count_out <= overrun_count_out + CNT_W'(1);
      end else if (clear_in) begin
        overrun_count_out <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (angles_valid_in && configured_in) begin
            roll_angle_out  <= roll_in;
            pitch_angle_out <= pitch_in;
            yaw_angle_out   <= yaw_in;
            r_sel           <= C_SEL_ROLL;
            r_state         <= S_ISSUE;
            busy_out        <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (!configured_in) begin
            r_state           <= S_IDLE;
            busy_out          <= 1'b0;
            output_select_out <= C_SEL_IDLE;
          end else begin
            write_enable_out  <= 1'b1;
            output_select_out <= r_sel;
            r_timer           <= '0;
            r_state           <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!configured_in) begin
            r_state           <= S_IDLE;
            busy_out          <= 1'b0;
            output_select_out <= C_SEL_IDLE;
          end else if (done_in) begin
            if (r_sel == C_SEL_YAW) begin
              frame_count_out   <= frame_count_out + CNT_W'(1);
              output_select_out <= C_SEL_IDLE;
              busy_out          <= 1'b0;
              r_state           <= S_IDLE;
            end else begin
              r_sel   <= r_sel + 2'd1;
              r_state <= S_ISSUE;
            end
          end else if (r_timer == C_TMR_LAST) begin
            timeout_err_out   <= 1'b1;
            output_select_out <= C_SEL_IDLE;
            busy_out          <= 1'b0;
            r_state           <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: begin
          r_state           <= S_IDLE;
          busy_out          <= 1'b0;
          output_select_out <= C_SEL_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_angle_output_sequencer.sv
`default_nettype none
// Directed bench for angle_output_sequencer: vector table plus hand-written
// multi-cycle sequences (timeout, config drop, done/timeout race, async reset).
module tb_angle_output_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        configured_in, angles_valid_in, done_in, clear_in;
  logic [15:0] roll_in, pitch_in, yaw_in;
  logic [15:0] roll_angle_out, pitch_angle_out, yaw_angle_out;
  logic        write_enable_out, busy_out, timeout_err_out;
  logic [1:0]  output_select_out;
  logic [7:0]  frame_count_out, overrun_count_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  angle_output_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .configured_in     (configured_in),
    .angles_valid_in   (angles_valid_in),
    .roll_in           (roll_in),
    .pitch_in          (pitch_in),
    .yaw_in            (yaw_in),
    .done_in           (done_in),
    .clear_in          (clear_in),
    .roll_angle_out    (roll_angle_out),
    .pitch_angle_out   (pitch_angle_out),
    .yaw_angle_out     (yaw_angle_out),
    .write_enable_out  (write_enable_out),
    .output_select_out (output_select_out),
    .busy_out          (busy_out),
    .frame_count_out   (frame_count_out),
    .overrun_count_out (overrun_count_out),
    .timeout_err_out   (timeout_err_out)
  );

  typedef struct {
    logic        cfg, valid, done, clr;
    logic [15:0] r, p, y;
    logic        we;
    logic [1:0]  sel;
    logic        busy;
    logic [7:0]  fc, oc;
    logic        err;
    logic [15:0] er, ep, ey;
  } vec_t;

  vec_t vecs[$];

  // Packed views: {we, sel, busy, err, frame_count, overrun_count}
  function automatic logic [20:0] ctl_act();
    return {write_enable_out, output_select_out, busy_out, timeout_err_out,
            frame_count_out, overrun_count_out};
  endfunction

  function automatic logic [20:0] ctl(input logic we, input logic [1:0] sel,
                                     input logic busy, input logic err,
                                     input logic [7:0] fc, input logic [7:0] oc);
    return {we, sel, busy, err, fc, oc};
  endfunction

  function automatic logic [47:0] snap_act();
    return {roll_angle_out, pitch_angle_out, yaw_angle_out};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic cfg, valid, done, clr,
                              input logic [15:0] r, p, y,
                              input logic we, input logic [1:0] sel,
                              input logic busy, input logic [7:0] fc, oc,
                              input logic err, input logic [15:0] er, ep, ey);
    vec_t v;
    v.cfg = cfg; v.valid = valid; v.done = done; v.clr = clr;
    v.r = r; v.p = p; v.y = y;
    v.we = we; v.sel = sel; v.busy = busy; v.fc = fc; v.oc = oc; v.err = err;
    v.er = er; v.ep = ep; v.ey = ey;
    vecs.push_back(v);
  endfunction

  // One frame, done answered 3 cycles after each strobe; optional overruns in the pitch wait.
  function automatic void add_frame(input logic [15:0] r, p, y,
                                    input logic [7:0] fc0, input logic ovr);
    logic [1:0] sel_pat [14] = '{3, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 3};
    logic [7:0] oc = 8'd0;
    for (int i = 0; i < 14; i++) begin
      logic vl, dn, we;
      logic [15:0] dr, dp, dy;
      vl = (i == 0) || (ovr && (i == 6 || i == 7));
      dn = (i == 4) || (i == 8) || (i == 12);
      we = (i == 1) || (i == 5) || (i == 9);
      dr = 16'h0; dp = 16'h0; dy = 16'h0;
      if (i == 0) begin dr = r; dp = p; dy = y; end
      else if (vl) begin dr = 16'hDEAD; dp = 16'hBEEF; dy = 16'hCAFE; end
      if (ovr && (i == 6 || i == 7)) oc = oc + 8'd1;
      add(1'b1, vl, dn, 1'b0, dr, dp, dy, we, sel_pat[i], (i < 12),
          (i >= 12) ? fc0 + 8'd1 : fc0, oc, 1'b0, r, p, y);
    end
  endfunction

  task automatic start_frame(input logic [15:0] r, p, y);
    roll_in = r; pitch_in = p; yaw_in = y; angles_valid_in = 1'b1;
    step();
    angles_valid_in = 1'b0; roll_in = 16'h0; pitch_in = 16'h0; yaw_in = 16'h0;
  endtask

  initial begin
    logic early;
    n_rst = 1'b0; configured_in = 1'b0; angles_valid_in = 1'b0;
    done_in = 1'b0; clear_in = 1'b0;
    roll_in = 16'h0; pitch_in = 16'h0; yaw_in = 16'h0;

    repeat (2) step();
    chk("reset_ctl", 64'(ctl_act()), 64'(ctl(0, 2'b11, 0, 0, 8'd0, 8'd0)));
    chk("reset_snap", 64'(snap_act()), 64'd0);
    n_rst = 1'b1;

    // Not configured: frame dropped silently.
    add(0, 1, 0, 0, 16'h1111, 16'h2222, 16'h3333, 0, 2'b11, 0, 8'd0, 8'd0, 0, 16'h0, 16'h0, 16'h0);
    add(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 2'b11, 0, 8'd0, 8'd0, 0, 16'h0, 16'h0, 16'h0);
    add_frame(16'h0F0F, 16'hA5A5, 16'h5E0D, 8'd0, 1'b0);
    add_frame(16'h1234, 16'h5678, 16'h9ABC, 8'd1, 1'b1);

    foreach (vecs[i]) begin
      configured_in = vecs[i].cfg; angles_valid_in = vecs[i].valid;
      done_in = vecs[i].done; clear_in = vecs[i].clr;
      roll_in = vecs[i].r; pitch_in = vecs[i].p; yaw_in = vecs[i].y;
      step();
      chk($sformatf("vec%0d_ctl", i), 64'(ctl_act()),
          64'(ctl(vecs[i].we, vecs[i].sel, vecs[i].busy, vecs[i].err, vecs[i].fc, vecs[i].oc)));
      chk($sformatf("vec%0d_snap", i), 64'(snap_act()),
          64'({vecs[i].er, vecs[i].ep, vecs[i].ey}));
    end
    configured_in = 1'b1; angles_valid_in = 1'b0; done_in = 1'b0; clear_in = 1'b0;
    roll_in = 16'h0; pitch_in = 16'h0; yaw_in = 16'h0;

    // Timeout after the pitch strobe: abort 64 edges after entering WAIT_DONE.
    start_frame(16'h0101, 16'h0202, 16'h0303);
    step();
    chk("to_roll_strobe", 64'(ctl_act()), 64'(ctl(1, 2'b00, 1, 0, 8'd2, 8'd2)));
    done_in = 1'b1; step(); done_in = 1'b0;
    step();
    chk("to_pitch_strobe", 64'(ctl_act()), 64'(ctl(1, 2'b01, 1, 0, 8'd2, 8'd2)));
    early = 1'b0;
    for (int k = 1; k < 64; k++) begin
      step();
      if (timeout_err_out || !busy_out) early = 1'b1;
    end
    chk("to_no_early_abort", 64'(early), 64'd0);
    step();
    chk("to_abort", 64'(ctl_act()), 64'(ctl(0, 2'b11, 0, 1, 8'd2, 8'd2)));
    clear_in = 1'b1; step(); clear_in = 1'b0;
    chk("to_clear", 64'(ctl_act()), 64'(ctl(0, 2'b11, 0, 0, 8'd2, 8'd0)));

    // Clear coinciding with overrun, then configured drop during the roll wait.
    start_frame(16'h0A0A, 16'h0B0B, 16'h0C0C);
    step();
    chk("cd_roll_strobe", 64'(ctl_act()), 64'(ctl(1, 2'b00, 1, 0, 8'd2, 8'd0)));
    clear_in = 1'b1; angles_valid_in = 1'b1;
    step();
    clear_in = 1'b0; angles_valid_in = 1'b0;
    chk("clear_vs_overrun", 64'(ctl_act()), 64'(ctl(0, 2'b00, 1, 0, 8'd2, 8'd1)));
    configured_in = 1'b0;
    step();
    chk("cfg_drop", 64'(ctl_act()), 64'(ctl(0, 2'b11, 0, 0, 8'd2, 8'd1)));
    configured_in = 1'b1;
    step();
    chk("cfg_drop_stays_idle", 64'(ctl_act()), 64'(ctl(0, 2'b11, 0, 0, 8'd2, 8'd1)));

    // done_in on the last allowed cycle of the yaw wait beats the timeout.
    start_frame(16'h4444, 16'h5555, 16'h6666);
    step();
    done_in = 1'b1; step(); done_in = 1'b0;
    step();
    done_in = 1'b1; step(); done_in = 1'b0;
    step();
    chk("race_yaw_strobe", 64'(ctl_act()), 64'(ctl(1, 2'b10, 1, 0, 8'd2, 8'd1)));
    early = 1'b0;
    for (int k = 1; k < 64; k++) begin
      step();
      if (timeout_err_out || !busy_out) early = 1'b1;
    end
    chk("race_no_early_abort", 64'(early), 64'd0);
    done_in = 1'b1; angles_valid_in = 1'b1;
    roll_in = 16'h7777; pitch_in = 16'h8888; yaw_in = 16'h9999;
    step();
    done_in = 1'b0; angles_valid_in = 1'b0;
    chk("race_done_wins", 64'(ctl_act()), 64'(ctl(0, 2'b11, 0, 0, 8'd3, 8'd2)));
    chk("race_snap_held", 64'(snap_act()), 64'({16'h4444, 16'h5555, 16'h6666}));

    // Valid one edge after busy falls starts a new frame.
    start_frame(16'h7777, 16'h8888, 16'h9999);
    chk("b2b_start_snap", 64'(snap_act()), 64'({16'h7777, 16'h8888, 16'h9999}));
    step();
    chk("b2b_strobe", 64'(ctl_act()), 64'(ctl(1, 2'b00, 1, 0, 8'd3, 8'd2)));

    // Asynchronous reset between clock edges.
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_reset_ctl", 64'(ctl_act()), 64'(ctl(0, 2'b11, 0, 0, 8'd0, 8'd0)));
    chk("async_reset_snap", 64'(snap_act()), 64'd0);
    step();
    n_rst = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/angle_output_sequencer.md
# angle_output_sequencer

Upstream feeder for the `Combined` MCU interface block. It captures each roll/pitch/yaw result frame from the attitude filter into stable snapshot registers. It then walks the MCU through one complete output cycle per frame: roll, then pitch, then yaw. Each step pulses `write_enable`, sets `output_select`, and waits for the MCU's `done`. The block also supervises the handshake, reporting frame overruns and done-timeouts to the controller.

## Interface
Parameters:
- TIMEOUT_CYCLES, 65535: maximum cycles in WAIT_DONE before the frame is aborted. Must be ≥ 2.
- CNT_W, 8: width of the frame and overrun counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- n_rst  in  1  reset, asynchronous and active-low.
- configured_in  in  1  MCU register map configured (from `configured_out`).
- angles_valid_in  in  1  one-cycle pulse: `roll_in`/`pitch_in`/`yaw_in` hold a new frame.
- roll_in, pitch_in, yaw_in  in  16 each  filter results.
- done_in  in  1  MCU finished shifting the current word (from `done_out`).
- clear_in  in  1  clears `timeout_err_out` and `overrun_count_out`.
- roll_angle_out, pitch_angle_out, yaw_angle_out  out  16 each  snapshot registers; drive `*_angle_in` of the MCU.
- write_enable_out  out  1  one-cycle load strobe to the MCU.
- output_select_out  out  2  00 = roll, 01 = pitch, 10 = yaw, 11 = idle.
- busy_out  out  1  high in every state except IDLE.
- frame_count_out  out  CNT_W  completed frames; wraps.
- overrun_count_out  out  CNT_W  dropped frames; saturates at all-ones.
- timeout_err_out  out  1  sticky; set on a done timeout.

## Operation
- Reset values:
  - all snapshots 0
  - write_enable_out 0
  - output_select_out 2'b11
  - busy_out 0
  - both counters 0
  - timeout_err_out 0
  - state IDLE, timer 0
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - When angles_valid_in & configured_in: load all three snapshots, set sel = 00, go to ISSUE.
  - When angles_valid_in & !configured_in: drop the frame silently; no counter change.
- ISSUE:
  - write_enable_out = 1 for exactly this one cycle.
  - output_select_out = sel.
  - Clear the timer and go to WAIT_DONE.
  - done_in is ignored in this state.
- WAIT_DONE:
  - output_select_out holds sel and the timer increments each cycle.
  - On done_in with sel ≠ 10: sel += 1, go to ISSUE.
  - On done_in with sel = 10: frame_count += 1 (wraps), output_select_out = 11, go to IDLE.
  - When the timer reaches TIMEOUT_CYCLES−1 without done_in: set timeout_err_out, go to IDLE, output_select_out = 11. The frame is not counted.
  - If done_in and the timeout occur in the same cycle, done_in wins.
- Overrun:
  - angles_valid_in while busy: overrun_count += 1, saturating.
  - Snapshots are not modified while busy, so the MCU always shifts one consistent frame.
- configured_in falling while busy: abort to IDLE on the next edge with output_select_out = 11. No counter changes and no error.
- clear_in:
  - Zeroes timeout_err_out and overrun_count_out on the next edge.
  - If clear_in coincides with a new overrun or timeout, the new event wins: count = 1, or err = 1.
- All outputs are registered; no combinational input-to-output paths.

## Timing
- angles_valid_in sampled high at edge N:
  - snapshots and busy_out update at N.
  - write_enable_out is high for the cycle between edges N+1 and N+2, with output_select_out = 00 already valid from edge N+1.
- done_in sampled at edge M in WAIT_DONE:
  - the next write_enable_out pulse is asserted from edge M+1.
  - minimum spacing between strobes is 2 cycles.
- Frame completion: busy_out falls and frame_count_out increments at the same edge that samples the final done_in.
- Timeout: abort at edge T0 + TIMEOUT_CYCLES, where T0 is the edge entering WAIT_DONE.
- Back-to-back frames: an angles_valid_in at the same edge busy_out falls counts as an overrun. One sampled at the following edge starts a new frame.

## Test plan
Tests use TIMEOUT_CYCLES = 64.
- Basic frame:
  - Stimulus: configured = 1; pulse valid with roll = 16'h0F0F, pitch = 16'hA5A5, yaw = 16'h5E0D; answer each strobe with done 3 cycles later.
  - Required: three strobes with selects 00, 01, 10 in that order; snapshots hold the values throughout; frame_count = 1; select returns to 11.
- Not configured:
  - Stimulus: configured = 0; pulse valid.
  - Required: no strobe, snapshots stay 0, all counters 0.
- Overrun:
  - Stimulus: pulse valid twice more during the pitch word, with different data.
  - Required: overrun_count = 2; the yaw word still uses the original snapshot; frame_count = 1.
- Timeout:
  - Stimulus: withhold done after the pitch strobe.
  - Required: timeout_err = 1 exactly 64 cycles after entering WAIT_DONE; busy = 0; frame_count unchanged.
  - Then pulse clear_in and require err = 0 and overrun_count = 0.
- Mid-frame disruptions:
  - Stimulus: drop configured during WAIT_DONE for roll.
  - Required: IDLE next edge, select = 11, no error.
  - Stimulus: assert n_rst low mid-frame.
  - Required: every output returns to its reset value immediately, without waiting for a clock edge.
- Same-cycle done and timeout:
  - Stimulus: done_in lands on cycle 63 of the yaw wait.
  - Required: frame completes, frame_count increments, timeout_err = 0.
